// File: rtl/dma_block_writer_if.sv
// DMA block writer bus bundle: CPU command, bus
// arbitration, device data and memory port-2 write.
interface dma_block_writer_if #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              br;
  logic              bg;
  logic [2:0]        blk_offset;
  logic [63:0]       dev_data;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_data;
  logic              interrupt_con;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    input  bg, dev_data,
    output busy, br, blk_offset,
    output mem_write, mem_address, mem_data,
    output interrupt_con
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    output bg, dev_data,
    input  busy, br, blk_offset,
    input  mem_write, mem_address, mem_data,
    input  interrupt_con
  );
endinterface

// File: rtl/dma_block_writer.sv
// DMA engine: requests the bus, writes device data to
// memory port 2 in 64-bit blocks, then interrupts the CPU.
module dma_block_writer #(
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WR_CYCLES   = 2
) (
  input logic clk,
  input logic reset_n,
  dma_block_writer_if.master bus
);
  localparam int NW  = LEN_W + 1;
  localparam int WCW =
    (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE, REQ, XFER, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [NW-1:0]     nblk_q, nblk_d;
  logic [2:0]        blk_q, blk_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [NW-1:0]     len_ext;
  logic              wr_last;
  logic              blk_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      nblk_q  <= '0;
      blk_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      nblk_q  <= nblk_d;
      blk_q   <= blk_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    len_ext  = NW'(bus.cmd_len);
    wr_last  = wcnt_q == WCW'(WR_CYCLES - 1);
    blk_last = NW'(blk_q) == nblk_q - NW'(1);
    state_d  = state_q;
    base_d   = base_q;
    nblk_d   = nblk_q;
    blk_d    = blk_q;
    wcnt_d   = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          base_d  = bus.cmd_addr;
          // ceil(len / BLOCK_WORDS) at LEN_W+1 bits
          nblk_d  = (len_ext + NW'(BLOCK_WORDS - 1))
                    / NW'(BLOCK_WORDS);
          state_d = (len_ext == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.bg) begin
          state_d = XFER;
          blk_d   = '0;
          wcnt_d  = '0;
        end
      end
      XFER: begin
        if (bus.bg) begin
          if (wr_last) begin
            wcnt_d = '0;
            if (blk_last) begin
              state_d = DONE;
              blk_d   = '0;
            end else begin
              blk_d = blk_q + 3'd1;
            end
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.br            = (state_q == REQ) ||
                        (state_q == XFER);
    bus.busy          = state_q != IDLE;
    bus.interrupt_con = state_q == DONE;
    bus.blk_offset    = blk_q;
    bus.mem_write     = 1'b0;
    bus.mem_address   = '0;
    bus.mem_data      = '0;
    if (state_q == XFER) begin
      bus.mem_write   = bus.bg;
      bus.mem_address = base_q + ADDR_W'(blk_q)
                        * ADDR_W'(BLOCK_WORDS);
      bus.mem_data    = bus.dev_data;
    end
  end
endmodule

// File: tb/tb_dma_block_writer.sv
// Scoreboard bench for dma_block_writer: random and
// directed commands against a block/word-level model.
module tb_dma_block_writer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dma_block_writer_if bus ();

  dma_block_writer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_wr[$];
  int   exp_irq[$];
  int   cmd_id = 0;
  logic [31:0] seed = 32'h0;
  logic bg_auto = 1'b0;
  logic bg_manual = 1'b0;
  logic mon_en = 1'b0;

  // device returns a per-command tag mixed with block index
  always_comb
    bus.dev_data = {seed, seed ^ {29'd0, bus.blk_offset}};

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  initial begin
    bus.bg = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bg_auto)
        bus.bg = bus.br && ($urandom_range(0, 3) != 0);
      else
        bus.bg = bg_manual;
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    if (mon_en) begin
      if (bus.mem_write && !(bus.br && bus.bg))
        chk("wr_without_grant", 1'b1, 1'b0);
      if (bus.br && !bus.busy)
        chk("br_without_busy", 1'b1, 1'b0);
      if (!bus.br && bus.blk_offset != 3'd0)
        chk("offset_outside_xfer", bus.blk_offset, 0);
      if (bus.mem_write) begin
        chk("wr_expected", exp_wr.size() > 0, 1'b1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", bus.mem_address, e.addr);
          chk("wr_data", bus.mem_data, e.data);
        end
      end
      if (bus.interrupt_con) begin
        chk("irq_expected", exp_irq.size() > 0, 1'b1);
        if (exp_irq.size() > 0) begin
          void'(exp_irq.pop_front());
          chk("irq_writes_left", exp_wr.size(), 0);
          chk("irq_br", bus.br, 1'b0);
          chk("irq_busy", bus.busy, 1'b1);
        end
      end
    end
  end

  task automatic model_cmd(input logic [15:0] a,
                           input logic [3:0] len);
    int nb;
    wr_t w;
    nb = (int'(len) + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 2; c++) begin
        w.addr = a + 16'(4 * b);
        w.data = {seed, seed ^ 32'(b)};
        exp_wr.push_back(w);
      end
    end
    exp_irq.push_back(cmd_id);
    cmd_id++;
  endtask

  task automatic send_cmd(input logic [15:0] a,
                          input logic [3:0] len,
                          input bit accept);
    @(negedge clk);
    #1;
    if (accept) begin
      seed = $urandom;
      model_cmd(a, len);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    @(negedge clk);
    if (accept) begin
      chk("accept_br", bus.br, len != 4'd0);
      chk("accept_busy", bus.busy, 1'b1);
      chk("accept_irq", bus.interrupt_con,
          len == 4'd0);
    end
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic stall_test();
    int xfer, stalls, sc, phase;
    bit seen;
    xfer = 0; stalls = 0; sc = 0; phase = 0;
    seen = 1'b0;
    bg_manual = 1'b1;
    send_cmd(16'h0100, 4'd5, 1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.mem_write) seen = 1'b1;
      if (seen && bus.br) begin
        xfer++;
        if (!bus.mem_write) stalls++;
      end
      if (phase == 0 && bus.mem_write &&
          bus.blk_offset == 3'd1) begin
        bg_manual = 1'b0;
        phase = 1;
      end else if (phase == 1) begin
        sc++;
        if (sc == 3) begin
          bg_manual = 1'b1;
          phase = 2;
        end
      end
      if (!bus.busy) break;
    end
    chk("stall_idle", bus.busy, 1'b0);
    chk("stall_xfer_cycles", xfer, 7);
    chk("stall_cycles", stalls, 3);
    bg_manual = 1'b0;
  endtask

  task automatic reset_test();
    int n;
    bg_auto = 1'b1;
    send_cmd(16'h0800, 4'd15, 1'b1);
    n = 0;
    while (!bus.mem_write && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_xfer", bus.mem_write, 1'b1);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_br", bus.br, 1'b0);
      chk("rst_mem_write", bus.mem_write, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_irq", bus.interrupt_con, 1'b0);
    end
    #1;
    reset_n = 1'b1;
    exp_wr.delete();
    exp_irq.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_irq", bus.interrupt_con, 1'b0);
      chk("post_rst_br", bus.br, 1'b0);
    end
    mon_en  = 1'b1;
    bg_auto = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [3:0]  l;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    repeat (3) @(negedge clk);
    chk("reset_br", bus.br, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_mem_write", bus.mem_write, 1'b0);
    chk("reset_irq", bus.interrupt_con, 1'b0);
    chk("reset_offset", bus.blk_offset, 0);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // three blocks, grant right after request
    bg_manual = 1'b0;
    send_cmd(16'h01F4, 4'd12, 1'b1);
    bg_manual = 1'b1;
    wait_idle(100);
    bg_manual = 1'b0;

    // zero length: straight to completion
    send_cmd(16'h1234, 4'd0, 1'b1);
    wait_idle(10);

    stall_test();

    bg_auto = 1'b1;
    send_cmd(16'hFFFC, 4'd8, 1'b1);
    wait_idle(100);

    // command while busy is dropped
    send_cmd(16'h0200, 4'd9, 1'b1);
    chk("busy_for_ignore", bus.busy, 1'b1);
    send_cmd(16'h0300, 4'd4, 1'b0);
    wait_idle(100);
    send_cmd(16'h0400, 4'd4, 1'b1);
    wait_idle(100);

    for (int t = 0; t < 25; t++) begin
      a = 16'($urandom);
      l = 4'($urandom_range(0, 15));
      send_cmd(a, l, 1'b1);
      if ($urandom_range(0, 2) == 0 && bus.busy)
        send_cmd(~a, ~l, 1'b0);
      wait_idle(200);
    end
    bg_auto = 1'b0;

    reset_test();
    send_cmd(16'h0040, 4'd4, 1'b1);
    bg_auto = 1'b1;
    wait_idle(100);

    repeat (3) @(negedge clk);
    chk("final_wr_queue", exp_wr.size(), 0);
    chk("final_irq_queue", exp_irq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
